// File: rtl/rib_timer.sv
// RIB responder timer: prescaled up-counter with periodic/one-shot modes
// and a level interrupt gated by CTRL.IE.
module rib_timer #(
  parameter int PRESC_W = 16,
  parameter int CNT_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic               en, ie, mode, irq;
  logic [PRESC_W-1:0] presc, pcnt;
  logic [CNT_W-1:0]   load, count;
  logic [2:0]         sel;
  logic               wr_ctrl, wr_presc, wr_load;
  logic               tick, term, start;
  logic               unused_bits;

  assign sel      = addr_i[4:2];
  assign wr_ctrl  = we_i && (sel == 3'd0);
  assign wr_presc = we_i && (sel == 3'd1);
  assign wr_load  = we_i && (sel == 3'd2);

  assign tick  = (state == RUN) && (pcnt == presc);
  assign term  = tick && (count == load);
  assign irq_o = ie & irq;

  assign unused_bits = ^{addr_i[31:5], addr_i[1:0], data_i};

  // Software writes to CTRL take priority over the one-shot stop.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_ctrl && data_i[0]) begin
          state_nx = RUN;
          start    = 1'b1;
        end
      end
      RUN: begin
        if (wr_ctrl)
          state_nx = data_i[0] ? RUN : IDLE;
        else if (term && mode)
          state_nx = DONE;
      end
      DONE: begin
        if (wr_ctrl) begin
          state_nx = data_i[0] ? RUN : IDLE;
          start    = data_i[0];
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      en    <= 1'b0;
      ie    <= 1'b0;
      mode  <= 1'b0;
      irq   <= 1'b0;
      presc <= '0;
      load  <= '0;
      pcnt  <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        pcnt  <= '0;
        count <= '0;
      end else if (state == RUN) begin
        if (tick) begin
          pcnt  <= '0;
          count <= term ? '0 : count + CNT_W'(1);
        end else begin
          pcnt <= pcnt + PRESC_W'(1);
        end
      end
      if (wr_ctrl) begin
        en   <= data_i[0];
        ie   <= data_i[1];
        mode <= data_i[2];
      end else if (term && mode) begin
        en <= 1'b0;
      end
      // Hardware set beats a same-cycle W1C.
      if (term)
        irq <= 1'b1;
      else if (wr_ctrl && data_i[3])
        irq <= 1'b0;
      if (wr_presc)
        presc <= data_i[PRESC_W-1:0];
      if (wr_load)
        load <= data_i[CNT_W-1:0];
    end
  end

  always_comb begin
    data_o = '0;
    unique case (sel)
      3'd0: data_o = {28'd0, irq, mode, ie, en};
      3'd1: data_o = 32'(presc);
      3'd2: data_o = 32'(load);
      3'd3: data_o = 32'(count);
      3'd4: data_o = {29'd0, tick, state};
      default: data_o = '0;
    endcase
  end

endmodule
